rng_arbiter: RTL
================

RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter WIDTH, default 10: random value / limit width in bits.
REQ-002 Parameter N_REQ, default 4: number of requesters (duck X, duck Y, direction, spawn delay).
REQ-003 Parameter STEPS, default 4: generator-enable cycles per draw; legal range 1..15.
REQ-004 Parameter MAX_TRIES, default 8: rejected draws before fallback; legal range 1..15.
REQ-005 Parameter IDLE_STIR, default 1: advance the generator while idle.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 req  in  N_REQ  per-requester draw request, level.
REQ-009 limit  in  N_REQ*WIDTH  per-requester exclusive upper bound; slice i = bits [i*WIDTH +: WIDTH]; 0 = full range.
REQ-010 lfsr_en  out  1  enable to the shared LFSR generator.
REQ-011 lfsr_value  in  WIDTH  current generator state.
REQ-012 gnt  out  N_REQ  one-hot owner of the current draw; all-zero when idle.
REQ-013 done  out  1  one-cycle pulse: result valid.
REQ-014 data  out  WIDTH  drawn value, valid when done=1.
REQ-015 fallback  out  1  with done: retry cap hit, data forced to 0.

Function
REQ-016 FSM states: IDLE, STEP, SAMPLE, DONE.
REQ-017 IDLE: req sampled only here; if any req bit set -> STEP next cycle, winner latched in gnt, its limit latched internally, step counter and try counter cleared.
REQ-018 Arbitration: round-robin; search starts at index (last winner + 1) mod N_REQ; after reset the search starts at index 0.
REQ-019 IDLE with no request: lfsr_en = IDLE_STIR; gnt = 0.
REQ-020 STEP: lfsr_en = 1 for exactly STEPS consecutive cycles, then -> SAMPLE.
REQ-021 SAMPLE: lfsr_en = 0; lfsr_value captured this cycle (one cycle after last enable).
REQ-022 Accept when latched limit == 0 or lfsr_value < latched limit (unsigned): data <= lfsr_value, fallback <= 0, -> DONE.
REQ-023 Reject otherwise: try counter += 1; if new count == MAX_TRIES: data <= 0, fallback <= 1, -> DONE; else -> STEP (new STEPS-cycle burst).
REQ-024 DONE: done = 1 for one cycle, gnt held, data/fallback stable; -> IDLE next cycle; gnt cleared in IDLE.
REQ-025 data and fallback hold their value until the next DONE.
REQ-026 Latency, accept on first try: done asserted STEPS+2 cycles after the IDLE cycle that sampled req; each rejection adds STEPS+1 cycles.
REQ-027 Deassertion of req or change of limit after grant does not abort or alter the draw in progress.
REQ-028 Requester still asserting req in the cycle after DONE is re-arbitrated normally, not guaranteed the next grant.
REQ-029 gnt is always zero or one-hot; lfsr_en is never asserted in SAMPLE or DONE.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, gnt = 0, done = 0, data = 0, fallback = 0, lfsr_en = 0, counters 0, round-robin pointer to start at index 0.
REQ-031 Reset mid-draw abandons the draw; no done pulse is produced for it.
REQ-032 Outputs resume per REQ-019 from the first clock edge after rst_n rises.

Verification
REQ-033 Defaults; req=0001, limit0=0, lfsr_value model from reset -> gnt=0001, lfsr_en high cycles 1-4, done at cycle 6, data = model value after 4 steps, fallback=0.
REQ-034 req=1111 held continuously, all limits 0 -> grant order 0,1,2,3,0,... with one done per grant and no skipped requester.
REQ-035 limit1=512, lfsr_value forced 700 on first SAMPLE then 100 -> one retry, done at cycle 11, data=100, gnt=0010.
REQ-036 limit2=1, lfsr_value forced 5 always -> 8 rejections, done with data=0, fallback=1.
REQ-037 rst_n pulsed low during STEP of a draw -> outputs 0 immediately, no done; next req=1000 served as first arbitration from index 0.
REQ-038 IDLE_STIR=1 with req=0 -> lfsr_en=1 every cycle; IDLE_STIR=0 -> lfsr_en=0 while idle.

Source files
------------

// File: rtl/rng_arbiter.sv
// Round-robin arbiter that serialises bounded random draws from one shared LFSR.
// Each grant runs STEPS generator-enable cycles, samples once, and retries on out-of-range values.
module rng_arbiter #(
    parameter int WIDTH     = 10,
    parameter int N_REQ     = 4,
    parameter int STEPS     = 4,
    parameter int MAX_TRIES = 8,
    parameter int IDLE_STIR = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] limit,
    output logic                   lfsr_en,
    input  logic [WIDTH-1:0]       lfsr_value,
    output logic [N_REQ-1:0]       gnt,
    output logic                   done,
    output logic [WIDTH-1:0]       data,
    output logic                   fallback,
    output logic [1:0]             dbg_state_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshake: req is a level sampled only in IDLE; the winner sees gnt from the
    // grant until its DONE cycle, and done pulses once there with data/fallback valid.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [3:0]         step_q, step_d;
    logic [3:0]         try_q, try_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               fallback_q, fallback_d;
    logic               done_q, done_d;
    logic               lfsr_en_q, lfsr_en_d;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [WIDTH-1:0]   win_limit;
    logic               accept;
    logic [3:0]         try_inc;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found     = 1'b0;
        win_idx   = '0;
        win_limit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % N_REQ]) begin
                found     = 1'b1;
                win_idx   = PTR_W'((int'(ptr_q) + i) % N_REQ);
                win_limit = limit[((int'(ptr_q) + i) % N_REQ) * WIDTH +: WIDTH];
            end
        end
    end

    assign accept  = (limit_q == '0) || (lfsr_value < limit_q);
    assign try_inc = try_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        limit_d    = limit_q;
        step_d     = step_q;
        try_d      = try_q;
        data_d     = data_q;
        fallback_d = fallback_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d = S_STEP;
                    gnt_d   = N_REQ'(1) << win_idx;
                    limit_d = win_limit;
                    step_d  = '0;
                    try_d   = '0;
                    ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                end
            end
            S_STEP: begin
                step_d = step_q + 4'd1;
                if (step_q == 4'(STEPS - 1)) begin
                    state_d = S_SAMPLE;
                    step_d  = '0;
                end
            end
            S_SAMPLE: begin
                if (accept) begin
                    data_d     = lfsr_value;
                    fallback_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    try_d = try_inc;
                    if (try_inc == 4'(MAX_TRIES)) begin
                        data_d     = '0;
                        fallback_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_STEP;
                        step_d  = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so reset drives them low cleanly.
    assign lfsr_en_d = (state_d == S_STEP) || ((state_d == S_IDLE) && (IDLE_STIR != 0));
    assign done_d    = (state_d == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            limit_q    <= '0;
            step_q     <= '0;
            try_q      <= '0;
            data_q     <= '0;
            fallback_q <= 1'b0;
            done_q     <= 1'b0;
            lfsr_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            limit_q    <= limit_d;
            step_q     <= step_d;
            try_q      <= try_d;
            data_q     <= data_d;
            fallback_q <= fallback_d;
            done_q     <= done_d;
            lfsr_en_q  <= lfsr_en_d;
        end
    end

    assign lfsr_en     = lfsr_en_q;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign data        = data_q;
    assign fallback    = fallback_q;
    assign dbg_state_o = state_q;

endmodule
